// File: rtl/mod_const_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : mod_const_mul_seq
// Description : Sequential modular constant multiplier, z = (x * K) mod M.
//               Bit-serial, MSB-first Horner evaluation: each RUN cycle
//               doubles the accumulator, reduces it, then conditionally adds
//               K and reduces again. No multiplier or divider is used.
//               It takes W RUN cycles per operand, with valid/ready
//               handshakes on both sides.
// Parameters  : M (modulus, 2..2^W), K (constant, 0..M-1), W (width)
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               in_valid  - x is valid
//               in_ready  - block can accept x (IDLE only)
//               x         - W-bit multiplicand, any value accepted
//               out_valid - z is valid (DONE)
//               out_ready - downstream accepts z
//               z         - W-bit result, always < M, held until next result
//               busy      - high in RUN or DONE
//               x_oor     - latched (x >= M) flag, only with MODMUL_OOR_CHK_EN
// Options     : MODMUL_OOR_CHK_EN - adds the x_oor port and its flag register
// Revision    : 1.0 - initial release
// ============================================================================
module mod_const_mul_seq #(
  parameter int M = 47,
  parameter int K = 24,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         busy
`ifdef MODMUL_OOR_CHK_EN
  ,
  output logic         x_oor
`endif
);

  // Counter must hold W-1; keep at least one bit for W=1.
  localparam int              CNT_W    = (W > 1) ? $clog2(W) : 1;
  // M may equal 2^W, so the modulus and all intermediates use W+1 bits.
  localparam logic [W:0]      M_EXT    = (W+1)'(M);
  localparam logic [W:0]      K_EXT    = (W+1)'(K);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  if (W < 1 || W > 30 || M < 2 || M > (1 << W) || K < 0 || K >= M) begin : g_param_err
    $error("mod_const_mul_seq: illegal parameters (need 2<=M<=2^W, 0<=K<M)");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     xs;
  logic [W:0]       acc;
  logic [CNT_W-1:0] cnt;

  logic [W:0]       dbl;
  logic [W:0]       dbl_red;
  logic [W:0]       sum;
  logic [W:0]       step;

  // One Horner step. acc < M <= 2^W, so the shift never loses a set bit and
  // every partial value stays below 2*M, which fits in W+1 bits.
  always_comb begin
    dbl     = acc << 1;
    dbl_red = (dbl >= M_EXT) ? (dbl - M_EXT) : dbl;
    sum     = dbl_red + K_EXT;
    if (xs[W-1]) begin
      step = (sum >= M_EXT) ? (sum - M_EXT) : sum;
    end else begin
      step = dbl_red;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs  <= '0;
      acc <= '0;
      cnt <= '0;
      z   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            xs  <= x;
            acc <= '0;
            cnt <= CNT_LAST;
          end
        end
        S_RUN: begin
          acc <= step;
          xs  <= xs << 1;
          if (cnt == '0) begin
            z <= step[W-1:0];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MODMUL_OOR_CHK_EN
  // Flags operands outside the residue range; the result is still the true
  // (x*K) mod M because the Horner recurrence never assumes x < M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_oor <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      x_oor <= ({1'b0, x} >= M_EXT);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_const_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_const_mul_seq
// Description : Self-checking bench for mod_const_mul_seq. Four instances with
//               different (M, K, W) share clock, reset and stimulus; one is
//               selected at a time. Expected results come from plain
//               arithmetic (x*K) % M.
// Options     : MODMUL_OOR_CHK_EN - also checks the x_oor flag
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_const_mul_seq;

  function automatic int cfg_m(input int c);
    case (c)
      0: return 47;
      1: return 64;
      2: return 3;
      default: return 47;
    endcase
  endfunction

  function automatic int cfg_k(input int c);
    case (c)
      0: return 24;
      1: return 63;
      2: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_w(input int c);
    case (c)
      2: return 2;
      default: return 6;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [5:0] x;
  int         sel;

  logic       in_ready_v  [4];
  logic       out_valid_v [4];
  logic       busy_v      [4];
  logic [5:0] z_v         [4];
`ifdef MODMUL_OOR_CHK_EN
  logic       oor_v       [4];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int GM = cfg_m(i);
    localparam int GK = cfg_k(i);
    localparam int GW = cfg_w(i);
    logic          rdy;
    logic          ov;
    logic          bsy;
    logic [GW-1:0] zl;
`ifdef MODMUL_OOR_CHK_EN
    logic          oor;
    assign oor_v[i] = oor;
`endif
    mod_const_mul_seq #(.M(GM), .K(GK), .W(GW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid && (sel == i)),
      .in_ready  (rdy),
      .x         (x[GW-1:0]),
      .out_valid (ov),
      .out_ready (out_ready && (sel == i)),
      .z         (zl),
      .busy      (bsy)
`ifdef MODMUL_OOR_CHK_EN
      ,
      .x_oor     (oor)
`endif
    );
    assign in_ready_v[i]  = rdy;
    assign out_valid_v[i] = ov;
    assign busy_v[i]      = bsy;
    assign z_v[i]         = 6'(zl);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full transaction on instance c: accept, latency, result, optional
  // stall in DONE with ignored input traffic, then release back to IDLE.
  task automatic xact(input int c, input int xv, input int gap, input int stall);
    int   m, k, w, exp_z, lat, n;
    logic stable;
    m     = cfg_m(c);
    k     = cfg_k(c);
    w     = cfg_w(c);
    exp_z = (xv * k) % m;
    sel   = c;
    repeat (gap) @(negedge clk);
    x        = 6'(xv);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready_v[c] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready_v[c]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    x        = 6'($urandom);
    check("busy_run", 32'(busy_v[c]), 32'd1);
    lat = 0;
    while (!out_valid_v[c] && lat < 4 * w + 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(w));
    check("z", 32'(z_v[c]), 32'(exp_z));
    check("busy_done", 32'(busy_v[c]), 32'd1);
`ifdef MODMUL_OOR_CHK_EN
    check("x_oor", 32'(oor_v[c]), 32'(xv >= m));
`endif
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      x        = 6'($urandom);
      @(negedge clk);
      if (out_valid_v[c] !== 1'b1 || z_v[c] !== 6'(exp_z) || in_ready_v[c] !== 1'b0)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    if (stall > 0) check("stall_hold", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_ready", 32'(in_ready_v[c]), 32'd1);
    check("release_ov", 32'(out_valid_v[c]), 32'd0);
    check("z_hold", 32'(z_v[c]), 32'(exp_z));
  endtask

  task automatic check_reset_values(input int c, input string tag);
    check({tag, "_in_ready"},  32'(in_ready_v[c]),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid_v[c]), 32'd0);
    check({tag, "_z"},         32'(z_v[c]),         32'd0);
    check({tag, "_busy"},      32'(busy_v[c]),      32'd0);
`ifdef MODMUL_OOR_CHK_EN
    check({tag, "_x_oor"},     32'(oor_v[c]),       32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    sel       = 0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++) check_reset_values(c, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operands on the default configuration
    xact(0, 1, 0, 0);
    xact(0, 2, 0, 0);
    xact(0, 46, 0, 0);
    xact(0, 0, 0, 0);
    xact(0, 63, 0, 0);
    xact(0, 47, 0, 0);

    // Backpressure: 10 stalled cycles in DONE with in_valid toggling
    xact(0, 5, 0, 10);

    // Back-to-back throughput with out_ready and in_valid held high
    sel       = 0;
    out_ready = 1'b1;
    x         = 6'd3;
    in_valid  = 1'b1;
    n = 0;
    while (!out_valid_v[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tp_first", 32'(out_valid_v[0]), 32'd1);
    check("tp_z", 32'(z_v[0]), 32'd25);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_v[0] && n < 40);
    check("throughput", 32'(n), 32'd8);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of RUN
    sel      = 0;
    x        = 6'd50;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_run_busy", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values(0, "mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_v[0] !== 1'b0) seen = 1'b1;
    end
    check("no_ov_after_reset", 32'(seen), 32'd0);
    xact(0, 1, 0, 0);

    // Exhaustive sweeps with random gaps and stalls
    for (int c = 0; c < 4; c++) begin
      for (int v = 0; v < (1 << cfg_w(c)); v++) begin
        xact(c, v, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
